// File: rtl/p1v_pkg.sv
// Shared P1V definitions: reset-cause codes and the reset generator state encoding.
package p1v_pkg;

   typedef enum logic [1:0] {
      RST_POR = 2'b00,
      RST_SW  = 2'b01,
      RST_WDT = 2'b10
   } rst_cause_e;

   typedef enum logic {
      RST_HOLD = 1'b0,
      RST_RUN  = 1'b1
   } rst_state_e;

endpackage

// File: rtl/p1v_rst_sync.sv
// Reset-release synchroniser: asserts asynchronously, releases SYNC_STAGES clock
// edges after rst_ni rises. Usable for any reset domain.
module p1v_rst_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic rst_sync_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   // Shift ones in from the bottom once the async reset is released.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/p1v_rstgen.sv
// P1V core reset generator. Holds nres low for HOLD_CYCLES after a synchronised
// board-reset release, turns the software reboot level into a timed reset and
// records why the last reset happened. Build with P1V_RSTGEN_WDT_EN defined to
// add the watchdog; without it wdt_kick is ignored and WDT is never reported.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RST_HOLD | nres low; hold counter runs once rst_sync is high
// RST_RUN  | nres high; reboot (or watchdog expiry) re-enters RST_HOLD
module p1v_rstgen
   import p1v_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned HOLD_CYCLES = 24'd8_000_000,
   parameter int unsigned WDT_CYCLES  = 24'hFF_FFFF
) (
   input  logic       clk_cog,
   input  logic       inp_resn,
   input  logic       reboot,
   input  logic       wdt_kick,
   output logic       nres,
   output logic [1:0] rst_cause
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   rst_state_e       state_q, state_d;
   rst_cause_e       cause_q, cause_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             nres_q;
   logic             rst_sync;

   p1v_rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rst_sync (
      .clk_i      (clk_cog),
      .rst_ni     (inp_resn),
      .rst_sync_o (rst_sync)
   );

`ifdef P1V_RSTGEN_WDT_EN
   localparam logic [CNT_W-1:0] WDT_MAX = CNT_W'(WDT_CYCLES - 1);

   logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;

   // Watchdog counter register; cleared by board reset.
   always_ff @(posedge clk_cog or negedge inp_resn) begin
      if (!inp_resn) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
      end
   end
`else
   localparam int unsigned wdt_cycles_unused = WDT_CYCLES;
   logic wdt_kick_unused;
   assign wdt_kick_unused = wdt_kick;
`endif

   // State, cause, hold counter and the single nres flop.
   always_ff @(posedge clk_cog or negedge inp_resn) begin
      if (!inp_resn) begin
         state_q    <= RST_HOLD;
         cause_q    <= RST_POR;
         hold_cnt_q <= '0;
         nres_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         hold_cnt_q <= hold_cnt_d;
         nres_q     <= (state_d == RST_RUN);
      end
   end

   // Next-state: release after the saturated hold count, reboot beats watchdog.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      hold_cnt_d = hold_cnt_q;
`ifdef P1V_RSTGEN_WDT_EN
      wdt_cnt_d  = '0;
`endif
      case (state_q)
         RST_HOLD: begin
            if (rst_sync) begin
               if (hold_cnt_q == HOLD_MAX) begin
                  if (!reboot) begin
                     state_d = RST_RUN;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + CNT_ONE;
               end
            end
         end
         RST_RUN: begin
            if (reboot) begin
               state_d    = RST_HOLD;
               hold_cnt_d = '0;
               cause_d    = RST_SW;
            end
`ifdef P1V_RSTGEN_WDT_EN
            else if (wdt_kick) begin
               wdt_cnt_d = '0;
            end else if (wdt_cnt_q == WDT_MAX) begin
               state_d    = RST_HOLD;
               hold_cnt_d = '0;
               cause_d    = RST_WDT;
            end else begin
               wdt_cnt_d = wdt_cnt_q + CNT_ONE;
            end
`endif
         end
      endcase
   end

   assign nres      = nres_q;
   assign rst_cause = cause_q;

endmodule

// File: tb/tb_p1v_rstgen.sv
// Directed bench for p1v_rstgen with HOLD_CYCLES=10, WDT_CYCLES=20, SYNC_STAGES=2.
// Watchdog sequences are exercised when P1V_RSTGEN_WDT_EN is defined; otherwise
// the bench confirms that no watchdog reset ever occurs.
module tb_p1v_rstgen;

   logic       clk_cog;
   logic       inp_resn;
   logic       reboot;
   logic       wdt_kick;
   logic       nres;
   logic [1:0] rst_cause;

   int total;
   int bad;

   p1v_rstgen #(
      .SYNC_STAGES (2),
      .CNT_W       (24),
      .HOLD_CYCLES (10),
      .WDT_CYCLES  (20)
   ) dut (
      .clk_cog   (clk_cog),
      .inp_resn  (inp_resn),
      .reboot    (reboot),
      .wdt_kick  (wdt_kick),
      .nres      (nres),
      .rst_cause (rst_cause)
   );

   initial clk_cog = 1'b0;
   always #5 clk_cog = ~clk_cog;

   typedef struct {
      logic       resn;
      logic       reboot;
      logic       kick;
      int         cycles;
      logic       exp_nres;
      logic [1:0] exp_cause;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] at %0t: got=%b want=%b", nm, idx, $time, act, exp);
      end
   endtask

   // Drive inputs now (off-edge), then check outputs after each of n rising edges.
   task automatic seg(input string nm, input logic rn, input logic rb, input logic kk,
                      input int n, input logic en, input logic [1:0] ec);
      inp_resn = rn;
      reboot   = rb;
      wdt_kick = kk;
      for (int c = 0; c < n; c++) begin
         @(posedge clk_cog);
         #1;
         chk({nm, ".nres"}, c, {1'b0, nres}, {1'b0, en});
         chk({nm, ".cause"}, c, rst_cause, ec);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      inp_resn = 1'b0;
      reboot   = 1'b0;
      wdt_kick = 1'b0;

      //            resn  reboot kick  n   nres  cause
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 11, 1'b0, 2'b00}; // POR hold, sync + count
      vecs[1]  = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 2'b00}; // release on edge 12
      vecs[2]  = '{1'b1, 1'b0, 1'b0,  5, 1'b1, 2'b00}; // running
      vecs[3]  = '{1'b1, 1'b1, 1'b0,  1, 1'b0, 2'b01}; // one-cycle SW reboot
      vecs[4]  = '{1'b1, 1'b0, 1'b0,  9, 1'b0, 2'b01}; // low for 10 edges total
      vecs[5]  = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 2'b01};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 30, 1'b0, 2'b01}; // reboot held 30 cycles
      vecs[7]  = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 2'b01}; // 1 edge after fall
      vecs[8]  = '{1'b1, 1'b0, 1'b1,  1, 1'b1, 2'b01}; // kick in RUN harmless
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 10, 1'b1, 2'b01};
      vecs[10] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 2'b00}; // board reset from RUN
      vecs[11] = '{1'b1, 1'b0, 1'b0, 11, 1'b0, 2'b00};
      vecs[12] = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 2'b00};

      // Reset state with inp_resn held low.
      repeat (2) @(posedge clk_cog);
      #1;
      chk("reset.nres", 0, {1'b0, nres}, 2'b00);
      chk("reset.cause", 0, rst_cause, 2'b00);

      for (int i = 0; i < NVEC; i++) begin
         seg($sformatf("vec%0d", i), vecs[i].resn, vecs[i].reboot, vecs[i].kick,
             vecs[i].cycles, vecs[i].exp_nres, vecs[i].exp_cause);
      end

      // Board-reset pulse in mid hold (count 5) after a SW reboot.
      seg("glitch.sw", 1'b1, 1'b1, 1'b0, 1, 1'b0, 2'b01);
      seg("glitch.cnt", 1'b1, 1'b0, 1'b0, 5, 1'b0, 2'b01);
      inp_resn = 1'b0;
      #2;
      chk("glitch.async_nres", 0, {1'b0, nres}, 2'b00);
      chk("glitch.async_cause", 0, rst_cause, 2'b00);
      seg("glitch.hold", 1'b1, 1'b0, 1'b0, 11, 1'b0, 2'b00);
      seg("glitch.rel", 1'b1, 1'b0, 1'b0, 1, 1'b1, 2'b00);

`ifdef P1V_RSTGEN_WDT_EN
      // No kicks: expiry 20 edges after entering RUN.
      seg("wdt.run", 1'b1, 1'b0, 1'b0, 19, 1'b1, 2'b00);
      seg("wdt.fire", 1'b1, 1'b0, 1'b0, 1, 1'b0, 2'b10);
      seg("wdt.hold", 1'b1, 1'b0, 1'b0, 9, 1'b0, 2'b10);
      seg("wdt.rel", 1'b1, 1'b0, 1'b0, 1, 1'b1, 2'b10);

      // Kick every 15 cycles keeps nres high for 200 cycles.
      for (int i = 1; i <= 200; i++) begin
         seg("wdt.kicked", 1'b1, 1'b0, (i % 15) == 0, 1, 1'b1, 2'b10);
      end

      // Fresh RUN entry via SW reboot.
      seg("fresh.sw", 1'b1, 1'b1, 1'b0, 1, 1'b0, 2'b01);
      seg("fresh.hold", 1'b1, 1'b0, 1'b0, 9, 1'b0, 2'b01);
      seg("fresh.rel", 1'b1, 1'b0, 1'b0, 1, 1'b1, 2'b01);

      // Reboot on the expiry cycle wins: cause SW, not WDT.
      seg("both.run", 1'b1, 1'b0, 1'b0, 19, 1'b1, 2'b01);
      seg("both.fire", 1'b1, 1'b1, 1'b0, 1, 1'b0, 2'b01);
      seg("both.hold", 1'b1, 1'b0, 1'b0, 9, 1'b0, 2'b01);
      seg("both.rel", 1'b1, 1'b0, 1'b0, 1, 1'b1, 2'b01);

      // Kick on the expiry cycle prevents the reset; next expiry 20 edges later.
      seg("kexp.run", 1'b1, 1'b0, 1'b0, 19, 1'b1, 2'b01);
      seg("kexp.kick", 1'b1, 1'b0, 1'b1, 1, 1'b1, 2'b01);
      seg("kexp.run2", 1'b1, 1'b0, 1'b0, 19, 1'b1, 2'b01);
      seg("kexp.fire", 1'b1, 1'b0, 1'b0, 1, 1'b0, 2'b10);
`else
      // Without the watchdog, RUN persists with no kicks at all.
      seg("nowdt.run", 1'b1, 1'b0, 1'b0, 60, 1'b1, 2'b00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/p1v_rstgen.md
# p1v_rstgen

Reset generator feeding the core reset `nres` of the P1V top level. It releases `nres` only after `inp_resn` has been synchronised and held stable for a programmable number of `clk_cog` cycles. It converts the core's software reboot request (`cfg[7]`) into a full timed reset, and it reports the cause of the last reset. An optional watchdog can also force a reboot.

## Interface
One clock; reset is asynchronous and active-low.

Parameters:
- `SYNC_STAGES`, default 2: flops in the reset-release synchroniser; must be at least 2.
- `CNT_W`, default 24: width of the hold and watchdog counters.
- `HOLD_CYCLES`, default 24'd8_000_000: cycles `nres` stays low after the synchronised release (100 ms at 80 MHz); must be at least 1.
- `WDT_CYCLES`, default 24'hFF_FFFF: watchdog timeout in cycles; must be at least 2.

Ports (clock and reset first):
- `clk_cog`, in, 1: core clock.
- `inp_resn`, in, 1: asynchronous active-low board reset.
- `reboot`, in, 1: software reboot request, level; connected to `cfg[7]`.
- `wdt_kick`, in, 1: single-cycle watchdog service pulse from the core.
- `nres`, out, 1: registered active-low core reset.
- `rst_cause`, out, 2: cause of the last reset.
  - 2'b00: POR
  - 2'b01: SW
  - 2'b10: WDT
  - 2'b11: reserved

## Operation
- States: HOLD (`nres`=0) and RUN (`nres`=1).
- `inp_resn` low, asynchronously:
  - state becomes HOLD, hold counter clears to 0, synchroniser clears to 0;
  - `nres`=0, `rst_cause`=POR, watchdog counter clears to 0.
- Synchroniser: an all-ones shift chain clocked from `inp_resn` release; its output `rst_sync` goes high `SYNC_STAGES` edges after `inp_resn` rises.
- HOLD:
  - hold counter increments only while `rst_sync`=1;
  - at `HOLD_CYCLES-1` it saturates;
  - the transition to RUN occurs on the next edge only if `reboot`=0. While `reboot` stays high, the block remains in HOLD with the counter saturated.
- RUN, `reboot`=1: next edge enters HOLD; hold counter clears to 0; `rst_cause` becomes SW.
- RUN, watchdog (RSTGEN_WDT_EN only):
  - watchdog counter increments each cycle;
  - `wdt_kick`=1 clears it to 0;
  - when it reaches `WDT_CYCLES-1` without a kick, the next edge enters HOLD with `rst_cause`=WDT.
- Priority in the same cycle: async reset, then `reboot`, then `wdt_kick`, then watchdog expiry. A kick on the expiry cycle prevents the reboot.
- `rst_cause` changes only on entry to HOLD and holds its value through RUN.
- The watchdog counter is held at 0 in HOLD.

## Timing
- Reset values: `nres`=0, `rst_cause`=2'b00, state HOLD, all counters 0.
- Power-on release: `nres` rises on rising edge number `SYNC_STAGES+HOLD_CYCLES` after `inp_resn` rises (setup met), provided `reboot`=0.
- `nres` assertion latencies:
  - from `reboot`: 1 edge;
  - from watchdog expiry: 1 edge after the counter reaches `WDT_CYCLES-1`;
  - from `inp_resn` low: immediate (asynchronous).
- SW/WDT reboot length: `nres` stays low for exactly `HOLD_CYCLES` edges. The synchroniser is already high, so there is no sync delay. `reboot` must be low by the final edge; otherwise the release waits for it.
- An `inp_resn` glitch during HOLD or RUN restarts the full POR sequence.
- `nres` is glitch-free: it is a single flop.

## Configuration
- Macro: `P1V_RSTGEN_WDT_EN`.
- Defined: watchdog counter and expiry logic are present, and `rst_cause` can report WDT.
- Undefined:
  - no watchdog counter is synthesised;
  - `wdt_kick` is ignored;
  - `rst_cause` never reports 2'b10;
  - `WDT_CYCLES` is unused.

## Structure
- Shared package `p1v_pkg`:
  - cause codes `RST_POR`, `RST_SW`, `RST_WDT`;
  - state encoding `RST_HOLD`, `RST_RUN`.
- Sub-module `p1v_rst_sync`: parameterised `SYNC_STAGES` async-assert / sync-deassert chain. It is reusable for other reset domains.
- Counters use `CNT_W` bits. Compares are against `HOLD_CYCLES-1` and `WDT_CYCLES-1`, so there is no wrap.

## Test plan
Bench parameters: `HOLD_CYCLES`=10, `WDT_CYCLES`=20, `SYNC_STAGES`=2.
- POR: `inp_resn` 0→1 with `reboot`=0 → `nres` rises on edge 12 after release; `rst_cause`=00.
- SW reboot: `reboot`=1 for 1 cycle in RUN → `nres` low on the next edge for exactly 10 edges; `rst_cause`=01.
- Held reboot: `reboot` high for 30 cycles → `nres` stays low until 1 edge after `reboot` falls.
- Watchdog (macro on): no kicks → `nres` falls 20 edges after entering RUN; `rst_cause`=10. A kick every 15 cycles keeps `nres` high for 200 cycles.
- Simultaneous `reboot` and watchdog expiry → `rst_cause`=01. Kick on the expiry cycle → no reset.
- Mid-hold `inp_resn` pulse low at hold count 5 → `nres` stays 0; `rst_cause`=00; the full 12-edge release restarts.
